// File: rtl/mxv_frame_parser_pkg.sv
// mxv_frame_parser_pkg: shared command, state and error encodings for the MxV frame parser.
// Rev 1.0
`default_nettype none
package mxv_frame_parser_pkg;

  typedef enum logic [2:0] {
    CMD_MAT_SIZE = 3'd1,
    CMD_RETX     = 3'd2,
    CMD_CAP_INIT = 3'd3,
    CMD_MAT      = 3'd4,
    CMD_VEC      = 3'd5
  } cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LEN       = 4'd1,
    ST_CMD       = 4'd2,
    ST_PAYLOAD   = 4'd3,
    ST_EOF_CHK   = 4'd4,
    ST_OPERATION = 4'd5,
    ST_TRANSMIT  = 4'd6,
    ST_CLEAR     = 4'd7,
    ST_ERR       = 4'd8
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CMD  = 2'd2,
    ERR_EOF  = 2'd3
  } err_t;

  localparam logic [7:0] FRAME_SOF = 8'hFE;
  localparam logic [7:0] FRAME_EOF = 8'hEF;

endpackage
`default_nettype wire

// File: rtl/mxv_byte_counter.sv
// mxv_byte_counter: loadable up-counter with terminal-count compare.
// Rev 1.0
`default_nettype none
module mxv_byte_counter
  import mxv_frame_parser_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (inc)
      count <= count + W'(1);
  end

  assign tc = (count == terminal);

endmodule
`default_nettype wire

// File: rtl/mxv_frame_parser.sv
// mxv_frame_parser: SOF/LEN/CMD/payload/EOF parser and MxV phase sequencer, rev 1.0.
// Define MXV_PARSER_TIMEOUT_EN to abort a frame after TO_CYCLES idle cycles (err_code 3).
`default_nettype none
module mxv_frame_parser
  import mxv_frame_parser_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            MAX_LEN   = 32,
  parameter logic [DW-1:0] SOF       = DW'(FRAME_SOF),
  parameter logic [DW-1:0] EOF       = DW'(FRAME_EOF),
  parameter int            TO_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              rx_data,
  input  logic                       rx_valid,
  input  logic                       op_done,
  input  logic                       tx_done,
  output logic [2:0]                 cmd_id,
  output logic [DW-1:0]              pld_data,
  output logic                       pld_valid,
  output logic [$clog2(MAX_LEN)-1:0] pld_idx,
  output logic                       mat_size_en,
  output logic                       mat_en,
  output logic                       vec_en,
  output logic                       operation_en,
  output logic                       transmit_en,
  output logic                       clear_en,
  output logic                       frame_ok,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);

  if (MAX_LEN < 2 || MAX_LEN >= (1 << DW) || TO_CYCLES < 2) begin : g_bad_params
    $error("mxv_frame_parser: unsupported MAX_LEN/TO_CYCLES");
  end

  parser_state_t state_q, state_d;
  err_t          err_d;
  logic [2:0]    cmd_d;
  logic [CW-1:0] len_q, len_d;
  logic [IW-1:0] cnt;
  logic          cnt_load, cnt_inc, cnt_tc;
  logic          pld_fire, ok_d, timeout, pld_win;

  mxv_byte_counter #(.W(IW)) u_pld_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (cnt_inc),
    .terminal (IW'(len_q - CW'(1))),
    .count    (cnt),
    .tc       (cnt_tc)
  );

`ifdef MXV_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES);
  logic [TW-1:0] to_cnt;
  logic          to_tc, in_frame;

  assign in_frame = state_q inside {ST_LEN, ST_CMD, ST_PAYLOAD, ST_EOF_CHK};

  // Held at zero outside a frame and on every byte; counts idle cycles otherwise.
  mxv_byte_counter #(.W(TW)) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_valid || !in_frame),
    .load_val ('0),
    .inc      (1'b1),
    .terminal (TW'(TO_CYCLES - 1)),
    .count    (to_cnt),
    .tc       (to_tc)
  );

  assign timeout = in_frame && !rx_valid && to_tc;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_t'(err_code);
    cmd_d    = cmd_id;
    len_d    = len_q;
    pld_fire = 1'b0;
    ok_d     = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SOF) begin
        state_d = ST_LEN;
        err_d   = ERR_NONE;
      end
      ST_LEN: begin
        cnt_load = 1'b1;
        if (rx_valid) begin
          if (int'(rx_data) > MAX_LEN) begin
            state_d = ST_ERR;
            err_d   = ERR_LEN;
          end else begin
            len_d   = CW'(rx_data);
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: if (rx_valid) begin
        if (rx_data >= DW'(CMD_MAT_SIZE) && rx_data <= DW'(CMD_VEC)) begin
          cmd_d   = rx_data[2:0];
          state_d = (len_q == '0) ? ST_EOF_CHK : ST_PAYLOAD;
        end else begin
          state_d = ST_ERR;
          err_d   = ERR_CMD;
        end
      end
      // Length-counted: SOF/EOF values inside the payload are plain data.
      ST_PAYLOAD: if (rx_valid) begin
        pld_fire = 1'b1;
        cnt_inc  = 1'b1;
        if (cnt_tc) state_d = ST_EOF_CHK;
      end
      ST_EOF_CHK: if (rx_valid) begin
        if (rx_data == EOF) begin
          ok_d = 1'b1;
          case (cmd_t'(cmd_id))
            CMD_RETX: state_d = ST_TRANSMIT;
            CMD_VEC:  state_d = ST_OPERATION;
            CMD_MAT:  state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_ERR;
          err_d   = ERR_EOF;
        end
      end
      ST_OPERATION: if (op_done) state_d = ST_TRANSMIT;
      ST_TRANSMIT:  if (tx_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_ERR;
      err_d   = ERR_EOF;
    end
  end

  // Payload enables cover every pld_valid cycle, including the last byte.
  assign pld_win = (state_d == ST_PAYLOAD) || pld_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cmd_id       <= '0;
      err_code     <= '0;
      pld_data     <= '0;
      pld_valid    <= 1'b0;
      pld_idx      <= '0;
      mat_size_en  <= 1'b0;
      mat_en       <= 1'b0;
      vec_en       <= 1'b0;
      operation_en <= 1'b0;
      transmit_en  <= 1'b0;
      clear_en     <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cmd_id       <= cmd_d;
      err_code     <= err_d;
      pld_valid    <= pld_fire;
      if (pld_fire) begin
        pld_data <= rx_data;
        pld_idx  <= cnt;
      end
      mat_size_en  <= pld_win && (cmd_d == CMD_MAT_SIZE);
      mat_en       <= pld_win && (cmd_d == CMD_MAT);
      vec_en       <= pld_win && (cmd_d == CMD_VEC);
      operation_en <= (state_d == ST_OPERATION);
      transmit_en  <= (state_d == ST_TRANSMIT);
      clear_en     <= (state_q == ST_CLEAR);
      frame_ok     <= ok_d;
      frame_err    <= (state_d == ST_ERR);
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mxv_frame_parser.sv
// tb_mxv_frame_parser: table-driven, hand-written and randomized frame checks for mxv_frame_parser.
// Rev 1.0
`default_nettype none
module tb_mxv_frame_parser;

  localparam int DW      = 8;
  localparam int MAX_LEN = 32;
  localparam int IW      = $clog2(MAX_LEN);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          op_done = 1'b0;
  logic          tx_done = 1'b0;
  logic [2:0]    cmd_id;
  logic [DW-1:0] pld_data;
  logic          pld_valid;
  logic [IW-1:0] pld_idx;
  logic          mat_size_en, mat_en, vec_en, operation_en, transmit_en;
  logic          clear_en, frame_ok, frame_err, busy;
  logic [1:0]    err_code;
  logic [27:0]   all_outs;

  always #5 clk = ~clk;

  mxv_frame_parser #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .op_done(op_done), .tx_done(tx_done), .cmd_id(cmd_id),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_idx(pld_idx),
    .mat_size_en(mat_size_en), .mat_en(mat_en), .vec_en(vec_en),
    .operation_en(operation_en), .transmit_en(transmit_en), .clear_en(clear_en),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  assign all_outs = {cmd_id, pld_data, pld_valid, pld_idx, mat_size_en, mat_en, vec_en,
                     operation_en, transmit_en, clear_en, frame_ok, frame_err, err_code, busy};

  int checks = 0, errors = 0;
  int cyc = 0, n_ok = 0, n_err = 0, n_clr = 0, en_bad = 0, ok_cyc = -1, clr_cyc = -1;
  logic [IW+7:0] got_q[$];
  logic [IW+7:0] exp_q[$];
  logic [7:0]    tx_q[$];
  logic [2:0]    last_cmd = 3'd0;

  // Which payload enable the command should raise: 1 -> mat_size, 4 -> mat, 5 -> vec.
  function automatic logic [2:0] exp_en(input logic [2:0] c);
    case (c)
      3'd1:    return 3'b100;
      3'd4:    return 3'b010;
      3'd5:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (pld_valid) begin
      got_q.push_back({pld_idx, pld_data});
      if ({mat_size_en, mat_en, vec_en} != exp_en(cmd_id)) en_bad++;
    end
    if (frame_ok)  begin n_ok++; ok_cyc = cyc; end
    if (frame_err) n_err++;
    if (clear_en)  begin n_clr++; clr_cyc = cyc; end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic mon_clear();
    got_q.delete();
    n_ok = 0; n_err = 0; n_clr = 0; en_bad = 0; ok_cyc = -1; clr_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input int gap_max);
    foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, gap_max));
  endtask

  task automatic run_phases(input logic [2:0] c);
    int k;
    if (c == 3'd5) begin
      k = 0;
      while (!operation_en && k < 20) begin @(negedge clk); k++; end
      check("operation_en_seen", operation_en, 1);
      send_byte(8'hFE, 0);
      check("operation_ignores_sof", {operation_en, busy}, 2'b11);
      op_done = 1'b1; tx_done = 1'b1;
      @(negedge clk);
      op_done = 1'b0; tx_done = 1'b0;
      check("op_done_wins", {operation_en, transmit_en}, 2'b01);
    end
    k = 0;
    while (!transmit_en && k < 20) begin @(negedge clk); k++; end
    check("transmit_en_seen", transmit_en, 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("transmit_hold", transmit_en, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("tx_done_to_idle", {transmit_en, busy}, 2'b00);
  endtask

  task automatic check_frame(input string tag, input int e_ok, input int e_er,
                             input logic [1:0] e_code, input int e_clr);
    check({tag, " frame_ok"}, n_ok, e_ok);
    check({tag, " frame_err"}, n_err, e_er);
    check({tag, " clear_en"}, n_clr, e_clr);
    check({tag, " err_code"}, err_code, e_code);
    check({tag, " cmd_id"}, cmd_id, last_cmd);
    check({tag, " busy"}, busy, 0);
    check({tag, " pld_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s pld[%0d]", tag, i), got_q[i], exp_q[i]);
    check({tag, " pld_enables"}, en_bad, 0);
    if (e_clr != 0) check({tag, " clear_after_ok"}, clr_cyc - ok_cyc, 1);
  endtask

  typedef struct {
    int           n;
    logic [95:0]  bytes;  // right-aligned, first byte most significant
    int           sof;
    int           ok;
    int           er;
    logic [1:0]   code;
    logic [2:0]   cmd;    // 0: frame does not accept a command
    int           npld;
    int           clr;
  } vec_t;

  localparam int NV = 13;
  vec_t tv[NV];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{7, {8'hFE, 8'h03, 8'h01, 8'h0A, 8'hFE, 8'hEF, 8'hEF}, 0, 1, 0, 2'd0, 3'd1, 3, 0};
    tv[1]  = '{2, {8'hFE, 8'h21},                                  0, 0, 1, 2'd1, 3'd0, 0, 0};
    tv[2]  = '{3, {8'hFE, 8'h02, 8'h07},                           0, 0, 1, 2'd2, 3'd0, 0, 0};
    tv[3]  = '{5, {8'hFE, 8'h01, 8'h04, 8'h55, 8'hAA},             0, 0, 1, 2'd3, 3'd4, 1, 0};
    tv[4]  = '{4, {8'hFE, 8'h00, 8'h03, 8'hEF},                    0, 1, 0, 2'd0, 3'd3, 0, 0};
    tv[5]  = '{6, {8'h12, 8'hEF, 8'hFE, 8'h00, 8'h01, 8'hEF},      2, 1, 0, 2'd0, 3'd1, 0, 0};
    tv[6]  = '{5, {8'hFE, 8'h01, 8'h03, 8'hFE, 8'hEF},             0, 1, 0, 2'd0, 3'd3, 1, 0};
    tv[7]  = '{4, {8'hFE, 8'h00, 8'h04, 8'hEF},                    0, 1, 0, 2'd0, 3'd4, 0, 1};
    tv[8]  = '{3, {8'hFE, 8'h00, 8'h00},                           0, 0, 1, 2'd2, 3'd0, 0, 0};
    tv[9]  = '{2, {8'hFE, 8'hFF},                                  0, 0, 1, 2'd1, 3'd0, 0, 0};
    tv[10] = '{3, {8'hFE, 8'h00, 8'h06},                           0, 0, 1, 2'd2, 3'd0, 0, 0};
    tv[11] = '{4, {8'hFE, 8'h00, 8'h02, 8'hEF},                    0, 1, 0, 2'd0, 3'd2, 0, 0};
    tv[12] = '{4, {8'hFE, 8'h00, 8'h05, 8'hEF},                    0, 1, 0, 2'd0, 3'd5, 0, 0};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < NV; t++) begin
      mon_clear(); tx_q.delete(); exp_q.delete();
      for (int i = 0; i < tv[t].n; i++) tx_q.push_back(tv[t].bytes[(tv[t].n-1-i)*8 +: 8]);
      for (int i = 0; i < tv[t].npld; i++) exp_q.push_back({IW'(i), tx_q[tv[t].sof+3+i]});
      if (tv[t].cmd != 3'd0) last_cmd = tv[t].cmd;
      send_frame(1);
      if (tv[t].ok != 0 && (tv[t].cmd == 3'd2 || tv[t].cmd == 3'd5)) run_phases(tv[t].cmd);
      repeat (3) @(negedge clk);
      check_frame($sformatf("vec%0d", t), tv[t].ok, tv[t].er, tv[t].code, tv[t].clr);
    end

    // Full-length frame: last index must be MAX_LEN-1, then a CLEAR pulse.
    mon_clear(); tx_q.delete(); exp_q.delete();
    tx_q.push_back(8'hFE); tx_q.push_back(8'(MAX_LEN)); tx_q.push_back(8'h04);
    for (int i = 0; i < MAX_LEN; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      tx_q.push_back(v);
      exp_q.push_back({IW'(i), v});
    end
    tx_q.push_back(8'hEF);
    last_cmd = 3'd4;
    send_frame(2);
    repeat (3) @(negedge clk);
    check_frame("maxlen", 1, 0, 2'd0, 1);
    if (got_q.size() > 0) check("maxlen last_idx", got_q[got_q.size()-1][IW+7:8], MAX_LEN - 1);

    // Reset in the middle of a payload, then a clean frame.
    mon_clear();
    send_byte(8'hFE, 0); send_byte(8'h05, 0); send_byte(8'h04, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    check("midframe busy", busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midframe reset outputs", all_outs, 0);
    @(negedge clk);
    rst = 1'b1;
    last_cmd = 3'd0;
    mon_clear(); tx_q.delete(); exp_q.delete();
    tx_q = '{8'hFE, 8'h00, 8'h03, 8'hEF};
    last_cmd = 3'd3;
    send_frame(0);
    repeat (3) @(negedge clk);
    check_frame("after_reset", 1, 0, 2'd0, 0);

    // Randomized frames against a frame-level model.
    for (int f = 0; f < 60; f++) begin
      int kind, len, e_ok, e_er, e_clr;
      logic [1:0] e_code;
      logic [7:0] c, v;
      int r;
      kind = $urandom_range(0, 6);
      mon_clear(); tx_q.delete(); exp_q.delete();
      repeat ($urandom_range(0, 2)) begin
        do v = 8'($urandom); while (v == 8'hFE);
        tx_q.push_back(v);
      end
      tx_q.push_back(8'hFE);
      e_ok = 0; e_er = 1; e_clr = 0; c = 8'd0;
      if (kind == 4) begin
        len = $urandom_range(MAX_LEN + 1, 255);
        tx_q.push_back(8'(len));
        e_code = 2'd1;
      end else if (kind == 5) begin
        tx_q.push_back(8'($urandom_range(0, MAX_LEN)));
        r = $urandom_range(0, 250);
        tx_q.push_back((r == 0) ? 8'd0 : 8'(r + 5));
        e_code = 2'd2;
      end else begin
        len = ($urandom_range(0, 3) == 0) ? MAX_LEN : $urandom_range(0, MAX_LEN);
        c = 8'($urandom_range(1, 5));
        tx_q.push_back(8'(len));
        tx_q.push_back(c);
        for (int i = 0; i < len; i++) begin
          r = $urandom_range(0, 5);
          v = (r == 0) ? 8'hFE : (r == 1) ? 8'hEF : 8'($urandom);
          tx_q.push_back(v);
          exp_q.push_back({IW'(i), v});
        end
        last_cmd = c[2:0];
        if (kind == 6) begin
          do v = 8'($urandom); while (v == 8'hEF);
          tx_q.push_back(v);
          e_code = 2'd3;
        end else begin
          tx_q.push_back(8'hEF);
          e_ok = 1; e_er = 0; e_code = 2'd0;
          e_clr = (c == 8'd4) ? 1 : 0;
        end
      end
      send_frame($urandom_range(0, 3));
      if (e_ok != 0 && (c == 8'd2 || c == 8'd5)) run_phases(c[2:0]);
      repeat (3) @(negedge clk);
      check_frame($sformatf("rnd%0d", f), e_ok, e_er, e_code, e_clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mxv_frame_parser.md
Name: mxv_frame_parser

Overview:
- Parametrised, length-counted successor of the MxV command control path.
- Parses UART byte frames `SOF, LEN, CMD, payload[LEN], EOF` and streams payload bytes with an index to the matrix/vector datapath.
- Sequences operation/transmit/clear phases and reports frame errors.
- Sits between the UART RX datapath and the MxV matrix RAMs / vector PIPO / TX path.

Parameters:
- DW, 8: byte width of rx_data and pld_data.
- MAX_LEN, 32: maximum payload bytes per frame.
- SOF, 8'hFE: start-of-frame byte.
- EOF, 8'hEF: end-of-frame byte.
- TO_CYCLES, 100000: inter-byte timeout in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- rx_data  in  DW  received byte, valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- op_done  in  1  datapath MxV operation finished (level or pulse).
- tx_done  in  1  TX path finished result transmission.
- cmd_id  out  3  command of the current/last accepted frame.
- pld_data  out  DW  payload byte.
- pld_valid  out  1  one-cycle strobe with pld_data.
- pld_idx  out  $clog2(MAX_LEN)  0-based payload index.
- mat_size_en / mat_en / vec_en  out  1  level: high while PAYLOAD of cmd 1 / 4 / 5.
- operation_en  out  1  level during OPERATION.
- transmit_en  out  1  level during TRANSMIT.
- clear_en  out  1  one-cycle pulse in CLEAR.
- frame_ok  out  1  one-cycle pulse on valid EOF.
- frame_err  out  1  one-cycle pulse on error.
- err_code  out  2  0 none, 1 LEN>MAX_LEN, 2 unknown CMD, 3 missing EOF/timeout; held until next SOF.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0; byte counter 0.
- The reset is synchronous and active-low; it overrides everything, including mid-frame and mid-TRANSMIT.
- All outputs are registered; every response appears in the cycle after the triggering rx_valid edge.
- Only cycles with rx_valid=1 consume bytes; rx_data is ignored otherwise.
- States: IDLE, LEN, CMD, PAYLOAD, EOF_CHK, OPERATION, TRANSMIT, CLEAR, ERR.
- IDLE: on a byte == SOF go to LEN; clear err_code. Other bytes are discarded.
- LEN: on a byte, latch len.
  - len > MAX_LEN: go to ERR, err_code=1.
  - Otherwise go to CMD.
- CMD: on a byte in 1..5, latch cmd_id.
  - len==0: go to EOF_CHK.
  - Else: go to PAYLOAD.
  - Any other value: go to ERR, err_code=2.
- PAYLOAD: each byte produces pld_valid=1, pld_data=byte, pld_idx=count, then count++.
  - After byte len-1, go to EOF_CHK.
  - Payload bytes equal to SOF or EOF are data, not delimiters. This is a new behaviour relative to the old FSM.
- EOF_CHK: a byte == EOF pulses frame_ok, then goes by cmd:
  - 2 → TRANSMIT
  - 5 → OPERATION
  - 4 → CLEAR
  - 1, 3 → IDLE
- EOF_CHK: any other byte → ERR, err_code=3.
- OPERATION: hold operation_en; go to TRANSMIT on op_done.
- TRANSMIT: hold transmit_en; go to IDLE on tx_done.
- OPERATION/TRANSMIT: bytes received here are ignored, including SOF.
- CLEAR: one cycle, clear_en=1, then IDLE.
- ERR: one cycle, frame_err=1, then IDLE.
- Simultaneous op_done and tx_done in OPERATION: only op_done is honoured.
- rx_valid in ERR/CLEAR is dropped.
- MAX_LEN boundary: len==MAX_LEN is legal; the last pld_idx is MAX_LEN-1 with no index wrap.

Optional Feature:
- Macro: MXV_PARSER_TIMEOUT_EN.
- Defined: a counter reloads on every rx_valid while in LEN/CMD/PAYLOAD/EOF_CHK. If TO_CYCLES cycles pass with no byte, go to ERR with err_code=3.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Decomposition:
- Shared package, Definitions_Package:
  - cmd_t enum {CMD_MAT_SIZE=1, CMD_RETX=2, CMD_CAP_INIT=3, CMD_MAT=4, CMD_VEC=5}.
  - parser_state_t enum.
  - err_t enum.
  - Constants FRAME_SOF and FRAME_EOF.
- Sub-module: mxv_byte_counter (load/increment/terminal-count compare). The timeout counter reuses it under the macro.

Test Plan:
- MAX_LEN=32. FE 03 01 0A FE EF EF → pld_valid ×3 with data 0A, FE, EF and idx 0..2; mat_size_en high during payload; frame_ok pulse; back to IDLE. Checks in-payload delimiter bytes.
- FE 00 05 EF → frame_ok, then operation_en. Assert op_done → transmit_en. Assert tx_done → IDLE, busy=0.
- FE 21 → frame_err with err_code=1. FE 02 07 → err_code=2. FE 01 04 55 AA → err_code=3; clear_en never asserted.
- FE 20 04 + 32 bytes + EF → last pld_idx=31; clear_en pulses exactly one cycle after frame_ok.
- Assert rst=0 for one clk mid-PAYLOAD → next cycle all outputs 0 and state IDLE. A fresh FE 00 03 EF then completes normally.
- With MXV_PARSER_TIMEOUT_EN and TO_CYCLES=100: send FE 01 then idle for 100 cycles → frame_err with err_code=3.
